// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module  : id_ex_stage
// Brief   : ID/EX pipeline register with load-use hazard detection, one-bubble
//           insertion and a saturating bubble counter.
// Revision: 1.0 - initial release
// ============================================================================
module id_ex_stage #(
    parameter int DATA_WIDTH   = 32,
    parameter int ALU_OP_WIDTH = 3,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    hold,
    input  logic                    ID_valid,
    input  logic [4:0]              ID_rs,
    input  logic [4:0]              ID_rt,
    input  logic [4:0]              ID_rd,
    input  logic                    ID_uses_rs,
    input  logic                    ID_uses_rt,
    input  logic [DATA_WIDTH-1:0]   ID_read_data_1,
    input  logic [DATA_WIDTH-1:0]   ID_read_data_2,
    input  logic [DATA_WIDTH-1:0]   ID_sign_ext_imm,
    input  logic                    ID_reg_write,
    input  logic                    ID_mem_read,
    input  logic                    ID_mem_write,
    input  logic                    ID_mem_to_reg,
    input  logic                    ID_alu_src,
    input  logic                    ID_reg_dst,
    input  logic [ALU_OP_WIDTH-1:0] ID_alu_op,
    output logic [4:0]              ID_EX_rs_out,
    output logic [4:0]              ID_EX_rt_out,
    output logic [4:0]              ID_EX_rd_out,
    output logic [DATA_WIDTH-1:0]   ID_EX_read_data_1_out,
    output logic [DATA_WIDTH-1:0]   ID_EX_read_data_2_out,
    output logic [DATA_WIDTH-1:0]   ID_EX_sign_ext_imm_out,
    output logic                    ID_EX_reg_write_out,
    output logic                    ID_EX_mem_read_out,
    output logic                    ID_EX_mem_write_out,
    output logic                    ID_EX_mem_to_reg_out,
    output logic                    ID_EX_alu_src_out,
    output logic                    ID_EX_reg_dst_out,
    output logic [ALU_OP_WIDTH-1:0] ID_EX_alu_op_out,
    output logic                    ID_EX_valid_out,
    output logic                    stall,
    output logic [CNT_WIDTH-1:0]    bubble_count
);

    logic [4:0]              r_rs, r_rt, r_rd;
    logic [DATA_WIDTH-1:0]   r_d1, r_d2, r_imm;
    logic                    r_reg_write, r_mem_read, r_mem_write;
    logic                    r_mem_to_reg, r_alu_src, r_reg_dst;
    logic [ALU_OP_WIDTH-1:0] r_alu_op;
    logic                    r_valid;
    logic [CNT_WIDTH-1:0]    r_cnt;

    logic w_hz;
    logic w_bubble;
    logic w_count;

    // A load in EX whose destination the ID instruction reads must be given one extra cycle.
    assign w_hz = r_valid & r_mem_read & (r_rt != 5'd0) & ID_valid &
                  ((ID_uses_rs & (ID_rs == r_rt)) | (ID_uses_rt & (ID_rt == r_rt)));

    assign stall    = w_hz & ~flush;
    assign w_bubble = rst | flush | (~hold & w_hz);
    assign w_count  = ~rst & ~flush & ~hold & w_hz & (r_cnt != {CNT_WIDTH{1'b1}});

    always_ff @(posedge clk) begin
        if (w_bubble) begin
            r_rs         <= 5'd0;
            r_rt         <= 5'd0;
            r_rd         <= 5'd0;
            r_d1         <= '0;
            r_d2         <= '0;
            r_imm        <= '0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_alu_src    <= 1'b0;
            r_reg_dst    <= 1'b0;
            r_alu_op     <= '0;
            r_valid      <= 1'b0;
        end else if (!hold) begin
            r_rs         <= ID_rs;
            r_rt         <= ID_rt;
            r_rd         <= ID_rd;
            r_d1         <= ID_read_data_1;
            r_d2         <= ID_read_data_2;
            r_imm        <= ID_sign_ext_imm;
            // An empty ID slot must not carry side-effecting control into EX.
            r_reg_write  <= ID_reg_write  & ID_valid;
            r_mem_read   <= ID_mem_read   & ID_valid;
            r_mem_write  <= ID_mem_write  & ID_valid;
            r_mem_to_reg <= ID_mem_to_reg & ID_valid;
            r_alu_src    <= ID_alu_src    & ID_valid;
            r_reg_dst    <= ID_reg_dst    & ID_valid;
            r_alu_op     <= ID_alu_op & {ALU_OP_WIDTH{ID_valid}};
            r_valid      <= ID_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_count) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign ID_EX_rs_out           = r_rs;
    assign ID_EX_rt_out           = r_rt;
    assign ID_EX_rd_out           = r_rd;
    assign ID_EX_read_data_1_out  = r_d1;
    assign ID_EX_read_data_2_out  = r_d2;
    assign ID_EX_sign_ext_imm_out = r_imm;
    assign ID_EX_reg_write_out    = r_reg_write;
    assign ID_EX_mem_read_out     = r_mem_read;
    assign ID_EX_mem_write_out    = r_mem_write;
    assign ID_EX_mem_to_reg_out   = r_mem_to_reg;
    assign ID_EX_alu_src_out      = r_alu_src;
    assign ID_EX_reg_dst_out      = r_reg_dst;
    assign ID_EX_alu_op_out       = r_alu_op;
    assign ID_EX_valid_out        = r_valid;
    assign bubble_count           = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_id_ex_stage
// Brief   : Self-checking bench for id_ex_stage against a pipeline-slot model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

    localparam int DW  = 32;
    localparam int AW  = 3;
    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst, flush, hold, ID_valid, ID_uses_rs, ID_uses_rt;
    logic [4:0] ID_rs, ID_rt, ID_rd;
    logic [DW-1:0] ID_read_data_1, ID_read_data_2, ID_sign_ext_imm;
    logic ID_reg_write, ID_mem_read, ID_mem_write, ID_mem_to_reg, ID_alu_src, ID_reg_dst;
    logic [AW-1:0] ID_alu_op;

    logic [4:0] o_rs, o_rt, o_rd;
    logic [DW-1:0] o_d1, o_d2, o_imm;
    logic o_rw, o_mr, o_mw, o_m2r, o_as, o_rdst, o_v, stall;
    logic [AW-1:0] o_op;
    logic [CW-1:0] bubble_count;

    id_ex_stage #(.DATA_WIDTH(DW), .ALU_OP_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .hold(hold), .ID_valid(ID_valid),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_rd(ID_rd),
        .ID_uses_rs(ID_uses_rs), .ID_uses_rt(ID_uses_rt),
        .ID_read_data_1(ID_read_data_1), .ID_read_data_2(ID_read_data_2),
        .ID_sign_ext_imm(ID_sign_ext_imm),
        .ID_reg_write(ID_reg_write), .ID_mem_read(ID_mem_read), .ID_mem_write(ID_mem_write),
        .ID_mem_to_reg(ID_mem_to_reg), .ID_alu_src(ID_alu_src), .ID_reg_dst(ID_reg_dst),
        .ID_alu_op(ID_alu_op),
        .ID_EX_rs_out(o_rs), .ID_EX_rt_out(o_rt), .ID_EX_rd_out(o_rd),
        .ID_EX_read_data_1_out(o_d1), .ID_EX_read_data_2_out(o_d2),
        .ID_EX_sign_ext_imm_out(o_imm),
        .ID_EX_reg_write_out(o_rw), .ID_EX_mem_read_out(o_mr), .ID_EX_mem_write_out(o_mw),
        .ID_EX_mem_to_reg_out(o_m2r), .ID_EX_alu_src_out(o_as), .ID_EX_reg_dst_out(o_rdst),
        .ID_EX_alu_op_out(o_op), .ID_EX_valid_out(o_v),
        .stall(stall), .bubble_count(bubble_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]    rs, rt, rd;
        logic [DW-1:0] d1, d2, imm;
        logic          rw, mr, mw, m2r, as, rdst;
        logic [AW-1:0] op;
        logic          v;
    } slot_t;

    slot_t  m_ex;
    int     m_cnt;
    int     total = 0;
    int     bad   = 0;
    slot_t  w_dut;
    slot_t  snap;

    assign w_dut = '{o_rs, o_rt, o_rd, o_d1, o_d2, o_imm, o_rw, o_mr, o_mw, o_m2r, o_as, o_rdst, o_op, o_v};

    // Does the instruction in ID need a value a load in EX has not yet produced?
    function automatic logic model_hz();
        logic dep;
        dep = (ID_uses_rs && ID_rs == m_ex.rt) || (ID_uses_rt && ID_rt == m_ex.rt);
        return m_ex.v && m_ex.mr && m_ex.rt != 0 && ID_valid && dep;
    endfunction

    function automatic logic model_stall();
        return model_hz() && !flush;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_ex  = '0;
            m_cnt = 0;
        end else if (flush) begin
            m_ex = '0;
        end else if (hold) begin
            m_ex = m_ex;
        end else if (model_hz()) begin
            m_ex = '0;
            if (m_cnt < SAT) m_cnt = m_cnt + 1;
        end else begin
            m_ex.rs  = ID_rs;  m_ex.rt = ID_rt;  m_ex.rd = ID_rd;
            m_ex.d1  = ID_read_data_1;
            m_ex.d2  = ID_read_data_2;
            m_ex.imm = ID_sign_ext_imm;
            m_ex.v   = ID_valid;
            m_ex.rw  = ID_valid ? ID_reg_write  : 1'b0;
            m_ex.mr  = ID_valid ? ID_mem_read   : 1'b0;
            m_ex.mw  = ID_valid ? ID_mem_write  : 1'b0;
            m_ex.m2r = ID_valid ? ID_mem_to_reg : 1'b0;
            m_ex.as  = ID_valid ? ID_alu_src    : 1'b0;
            m_ex.rdst= ID_valid ? ID_reg_dst    : 1'b0;
            m_ex.op  = ID_valid ? ID_alu_op     : '0;
        end
    end

    task automatic drive_instr(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd, input logic urs, input logic urt,
                               input logic mr);
        ID_valid = v; ID_rs = rs; ID_rt = rt; ID_rd = rd;
        ID_uses_rs = urs; ID_uses_rt = urt; ID_mem_read = mr;
        ID_reg_write = 1'b1; ID_mem_to_reg = mr; ID_mem_write = 1'b0;
        ID_alu_src = mr; ID_reg_dst = ~mr; ID_alu_op = AW'($urandom);
        ID_read_data_1 = $urandom; ID_read_data_2 = $urandom; ID_sign_ext_imm = $urandom;
    endtask

    task automatic drive_random();
        ID_valid = ($urandom_range(0, 7) != 0);
        ID_rs = 5'($urandom_range(0, 3)); ID_rt = 5'($urandom_range(0, 3));
        ID_rd = 5'($urandom);
        ID_uses_rs = $urandom; ID_uses_rt = $urandom;
        ID_read_data_1 = $urandom; ID_read_data_2 = $urandom; ID_sign_ext_imm = $urandom;
        ID_reg_write = $urandom; ID_mem_read = ($urandom_range(0, 2) == 0);
        ID_mem_write = $urandom; ID_mem_to_reg = $urandom; ID_alu_src = $urandom;
        ID_reg_dst = $urandom; ID_alu_op = AW'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; hold = 1'b0;
        drive_random();
        repeat (2) @(negedge clk);
        total++;
        if (w_dut !== '0) begin bad++; $display("FAIL reset_regs got=%h want=0", w_dut); end
        total++;
        if (bubble_count !== '0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", bubble_count); end
        drive_instr(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", stall); end
        rst = 1'b0;
    endtask

    task automatic test_load_use();
        drive_instr(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        drive_instr(1'b1, 5'd2, 5'd4, 5'd3, 1'b1, 1'b1, 1'b0);
        #1;
        total++;
        if (stall !== 1'b1) begin bad++; $display("FAIL lu_stall got=%b want=1", stall); end
        @(negedge clk);
        total++;
        if (o_v !== 1'b0 || o_rw !== 1'b0 || bubble_count !== CW'(1)) begin
            bad++; $display("FAIL lu_bubble got v=%b rw=%b cnt=%0d want 0 0 1", o_v, o_rw, bubble_count);
        end
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL lu_stall_drop got=%b want=0", stall); end
        @(negedge clk);
        total++;
        if (o_v !== 1'b1 || o_rd !== 5'd3 || o_rs !== 5'd2 || w_dut !== m_ex) begin
            bad++; $display("FAIL lu_add_ex got=%h want=%h", w_dut, m_ex);
        end
    endtask

    task automatic test_rt_zero();
        drive_instr(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        drive_instr(1'b1, 5'd0, 5'd4, 5'd3, 1'b1, 1'b1, 1'b0);
        #1;
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL rt0_stall got=%b want=0", stall); end
        @(negedge clk);
        total++;
        if (o_v !== 1'b1 || o_rd !== 5'd3 || o_mr !== 1'b0 || bubble_count !== CW'(1)) begin
            bad++; $display("FAIL rt0_add got v=%b rd=%0d mr=%b cnt=%0d want 1 3 0 1", o_v, o_rd, o_mr, bubble_count);
        end
    endtask

    task automatic test_flush_hz();
        drive_instr(1'b1, 5'd1, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        drive_instr(1'b1, 5'd6, 5'd5, 5'd7, 1'b1, 1'b1, 1'b0);
        flush = 1'b1;
        #1;
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL fl_stall got=%b want=0", stall); end
        @(negedge clk);
        flush = 1'b0;
        total++;
        if (w_dut !== '0 || bubble_count !== CW'(1)) begin
            bad++; $display("FAIL fl_bubble got=%h cnt=%0d want=0 cnt=1", w_dut, bubble_count);
        end
    endtask

    task automatic test_hold();
        drive_instr(1'b1, 5'd1, 5'd9, 5'd2, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        snap = w_dut;
        drive_instr(1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 1'b1, 1'b0);
        ID_read_data_1 = 32'hDEADBEEF;
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (w_dut !== snap) begin bad++; $display("FAIL hold_frozen cyc=%0d got=%h want=%h", i, w_dut, snap); end
        end
        hold = 1'b0;
        @(negedge clk);
        total++;
        if (o_d1 !== 32'hDEADBEEF || o_rd !== 5'd5) begin
            bad++; $display("FAIL hold_release got d1=%h rd=%0d want deadbeef 5", o_d1, o_rd);
        end
        // A hazard held for two cycles keeps stalling and only bubbles afterwards.
        drive_instr(1'b1, 5'd1, 5'd6, 5'd0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        drive_instr(1'b1, 5'd6, 5'd1, 5'd8, 1'b1, 1'b0, 1'b0);
        hold = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            total++;
            if (stall !== 1'b1) begin bad++; $display("FAIL hold_hz_stall cyc=%0d got=%b want=1", i, stall); end
            @(negedge clk);
        end
        hold = 1'b0;
        @(negedge clk);
        total++;
        if (o_v !== 1'b0 || bubble_count !== CW'(2)) begin
            bad++; $display("FAIL hold_hz_bubble got v=%b cnt=%0d want 0 2", o_v, bubble_count);
        end
        @(negedge clk);
        total++;
        if (o_v !== 1'b1 || o_rd !== 5'd8) begin bad++; $display("FAIL hold_hz_load got v=%b rd=%0d want 1 8", o_v, o_rd); end
    endtask

    task automatic test_back_to_back();
        drive_instr(1'b1, 5'd1, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        drive_instr(1'b1, 5'd1, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1);
        #1;
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL b2b_indep got=%b want=0", stall); end
        @(negedge clk);
        drive_instr(1'b1, 5'd9, 5'd10, 5'd0, 1'b1, 1'b0, 1'b1);
        #1;
        total++;
        if (stall !== 1'b1) begin bad++; $display("FAIL b2b_dep got=%b want=1", stall); end
        @(negedge clk);
        @(negedge clk);
        total++;
        if (o_rt !== 5'd10 || o_mr !== 1'b1 || bubble_count !== CW'(3)) begin
            bad++; $display("FAIL b2b_second got rt=%0d mr=%b cnt=%0d want 10 1 3", o_rt, o_mr, bubble_count);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive_random();
            rst   = ($urandom_range(0, 63) == 0);
            flush = ($urandom_range(0, 9) == 0);
            hold  = ($urandom_range(0, 7) == 0);
            #1;
            total++;
            if (stall !== model_stall()) begin bad++; $display("FAIL rnd_stall i=%0d got=%b want=%b", i, stall, model_stall()); end
            @(negedge clk);
            total++;
            if (w_dut !== m_ex || bubble_count !== CW'(m_cnt)) begin
                bad++; $display("FAIL rnd_state i=%0d got=%h/%0d want=%h/%0d", i, w_dut, bubble_count, m_ex, m_cnt);
            end
        end
        rst = 1'b0; flush = 1'b0; hold = 1'b0;
    endtask

    task automatic test_saturation();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < (1 << CW) + 3; i++) begin
            drive_instr(1'b1, 5'd1, 5'd3, 5'd0, 1'b0, 1'b0, 1'b1);
            @(negedge clk);
            drive_instr(1'b1, 5'd3, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0);
            @(negedge clk);
        end
        total++;
        if (bubble_count !== 4'hF) begin bad++; $display("FAIL sat_cnt got=%h want=f", bubble_count); end
    endtask

    task automatic test_mid_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive_instr(1'b1, 5'd1, 5'd4, 5'd0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        drive_instr(1'b1, 5'd4, 5'd2, 5'd6, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (w_dut !== '0 || bubble_count !== '0) begin
            bad++; $display("FAIL midrst got=%h cnt=%0d want=0 cnt=0", w_dut, bubble_count);
        end
        #1;
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL midrst_stall got=%b want=0", stall); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_rt_zero();
        test_flush_hz();
        test_hold();
        test_back_to_back();
        test_random();
        test_saturation();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
